multi_alarm_clock: RTL
======================

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameter NUM_ALARMS, default 4: number of independent alarm channels (1..8).
REQ-002 Parameter TICKS_PER_MIN, default 60: clk cycles per clock minute (>=2).
REQ-003 Parameter SNOOZE_MIN, default 5: snooze length in minutes (1..15).
REQ-004 Parameter RING_MIN, default 10: ring timeout in minutes (1..15).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 set_time  in  1  one-cycle pulse: load set_hours/set_minutes into the time registers.
REQ-008 set_hours  in  6  BCD hours {tens[1:0], units[3:0]}.
REQ-009 set_minutes  in  7  BCD minutes {tens[2:0], units[3:0]}.
REQ-010 set_alarm  in  1  one-cycle pulse: load set_hours/set_minutes into channel alarm_sel.
REQ-011 alarm_sel  in  3  target channel; values >= NUM_ALARMS are ignored.
REQ-012 alarm_on  in  NUM_ALARMS  per-channel enable, level.
REQ-013 snooze  in  1  one-cycle pulse, applies to all ringing channels.
REQ-014 dismiss  in  1  one-cycle pulse, applies to all ringing or snoozed channels.
REQ-015 hours  out  6  current hours, BCD, 00..23.
REQ-016 minutes  out  7  current minutes, BCD, 00..59.
REQ-017 alarm_active  out  NUM_ALARMS  per-channel ringing flag.
REQ-018 alarm_triggered  out  1  OR of alarm_active.

Function
REQ-019 Prescaler counts 0..TICKS_PER_MIN-1; min_tick is high in the cycle the count is TICKS_PER_MIN-1, and the count wraps to 0.
REQ-020 On min_tick, minutes increments in BCD; 59 wraps to 00 and increments hours; 23:59 wraps to 00:00.
REQ-021 set_time has priority over min_tick, clears the prescaler, and takes effect at the next edge.
REQ-022 set_time or set_alarm with invalid BCD (unit >9, minutes >59, hours >23) is ignored entirely.
REQ-023 A time-update event occurs at any edge where the time registers are written by min_tick or set_time; it is registered as ev_q.
REQ-024 Each channel FSM has the states IDLE, RINGING, and SNOOZED; alarm_active[i] is high only in RINGING.
REQ-025 IDLE->RINGING when ev_q=1, alarm_on[i]=1, and time equals alarm[i]; alarm_active rises one cycle after the matching time is loaded.
REQ-026 RINGING->IDLE on dismiss, or after RING_MIN min_ticks spent in RINGING.
REQ-027 RINGING->SNOOZED on snooze, and the snooze counter loads SNOOZE_MIN; in SNOOZED the counter decrements on each min_tick, and the channel goes SNOOZED->RINGING with the ring timer restarted at the min_tick that takes the counter to 0.
REQ-028 SNOOZED->IDLE on dismiss.
REQ-029 Dismiss and snooze in the same cycle: dismiss wins.
REQ-030 Deasserting alarm_on[i] forces channel i to IDLE at the next edge, with priority over every other transition.
REQ-031 set_alarm on channel i loads the new alarm time and forces channel i to IDLE; loading the current time does not ring until the next matching event.
REQ-032 Channels are independent; several channels may ring simultaneously.

Reset
REQ-033 While rst=0, all state clears asynchronously: time 00:00, all alarm times 00:00, prescaler 0, all channels IDLE, all counters 0, alarm_active=0, alarm_triggered=0.
REQ-034 Reset asserted mid-ring or mid-snooze abandons that operation; there is no retained state.

Configuration
REQ-035 Macro MULTI_ALARM_SNOOZE_EN defined: snooze behaves per REQ-027.
REQ-036 Macro undefined: the SNOOZED state and snooze counter are not built, the snooze input is ignored, and RINGING exits only via dismiss, timeout, or REQ-030/031.

Structure
REQ-037 Package multi_alarm_clock_pkg holds: the channel state typedef (IDLE/RINGING/SNOOZED), the BCD width constants (6/7), the max hour/minute constants (23/59), and the BCD validity and increment functions.
REQ-038 Sub-module alarm_channel contains the per-channel FSM, the alarm-time register, the ring timer, and the snooze counter; it is instantiated NUM_ALARMS times via generate.

Verification (TICKS_PER_MIN=4, SNOOZE_MIN=2, RING_MIN=3)
REQ-039 Stimulus: set_time 23:59, then 4 cycles. Required response: hours=00, minutes=00.
REQ-040 Stimulus: alarm0=07:30, alarm_on=0001, set_time 07:29, then 4 cycles. Required response: minutes=30, and alarm_active[0]=1 and alarm_triggered=1 one cycle later.
REQ-041 Stimulus: snooze while channel 0 is ringing. Required response: alarm_active[0]=0; alarm_active[0]=1 again after 2 min_ticks (8 cycles). With MULTI_ALARM_SNOOZE_EN undefined, the channel stays ringing.
REQ-042 Stimulus: no action while ringing. Required response: alarm_active[0]=0 after 3 min_ticks (12 cycles). Stimulus: snooze and dismiss pulsed together. Required response: IDLE with no re-ring.
REQ-043 Stimulus: set_time 25:70. Required response: time unchanged. Stimulus: set_alarm with alarm_sel=5 and NUM_ALARMS=4. Required response: no channel changes.
REQ-044 Stimulus: channels 1 and 2 both at 12:00, enabled; reach 12:00. Required response: alarm_active=0110. Then clear alarm_on[1]. Required response: alarm_active=0100 next cycle. Stimulus: rst low while ringing. Required response: all outputs 0 immediately.

Source files
------------

// File: rtl/multi_alarm_clock_pkg.sv
// multi_alarm_clock_pkg: shared channel state type, BCD widths/limits and BCD time helpers.
package multi_alarm_clock_pkg;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} ch_state_t;
  localparam int HOUR_W = 6;
  localparam int MIN_W = 7;
  localparam logic [HOUR_W-1:0] MAX_HOUR = 6'h23;
  localparam logic [MIN_W-1:0] MAX_MIN = 7'h59;
  // BCD ordering matches numeric ordering once the units digits are known valid
  function automatic logic bcd_valid(input logic [HOUR_W-1:0] h, input logic [MIN_W-1:0] m);
    return h[3:0] <= 4'd9 && m[3:0] <= 4'd9 && h <= MAX_HOUR && m <= MAX_MIN;
  endfunction
  function automatic logic [MIN_W-1:0] bcd_inc_min(input logic [MIN_W-1:0] m);
    return m == MAX_MIN ? '0 : m[3:0] == 4'd9 ? {m[6:4] + 3'd1, 4'd0} : {m[6:4], m[3:0] + 4'd1};
  endfunction
  function automatic logic [HOUR_W-1:0] bcd_inc_hour(input logic [HOUR_W-1:0] h);
    return h == MAX_HOUR ? '0 : h[3:0] == 4'd9 ? {h[5:4] + 2'd1, 4'd0} : {h[5:4], h[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/multi_alarm_clock_channel.sv
// alarm_channel: one alarm slot with alarm time, ring timer and FSM.
// Snooze state and counter exist only with MULTI_ALARM_SNOOZE_EN defined.
module alarm_channel import multi_alarm_clock_pkg::*; #(
`ifdef MULTI_ALARM_SNOOZE_EN
  parameter int SNOOZE_MIN = 5,
`endif
  parameter int RING_MIN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev,
  input  logic              min_tick,
  input  logic              en,
  input  logic              load,
  input  logic              dismiss,
`ifdef MULTI_ALARM_SNOOZE_EN
  input  logic              snooze,
`endif
  input  logic [HOUR_W-1:0] set_hours,
  input  logic [MIN_W-1:0]  set_minutes,
  input  logic [HOUR_W-1:0] hours,
  input  logic [MIN_W-1:0]  minutes,
  output logic              active
);
  localparam logic [3:0] RING_L = 4'(RING_MIN);
  ch_state_t state;
  logic [HOUR_W-1:0] alarm_hours;
  logic [MIN_W-1:0] alarm_minutes;
  logic [3:0] ring_cnt;
  logic match;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam logic [3:0] SNOOZE_L = 4'(SNOOZE_MIN);
  logic [3:0] snooze_cnt;
`endif
  assign match = hours == alarm_hours && minutes == alarm_minutes;
  assign active = state == RINGING;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      alarm_hours <= '0;
      alarm_minutes <= '0;
      ring_cnt <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      snooze_cnt <= '0;
`endif
    end else begin
      if (load) begin
        alarm_hours <= set_hours;
        alarm_minutes <= set_minutes;
      end
      // disable and reprogramming override every other transition
      if (!en || load) state <= IDLE;
      else
        case (state)
          IDLE:
            if (ev && match) begin
              state <= RINGING;
              ring_cnt <= RING_L;
            end
          RINGING:
            if (dismiss) state <= IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
            else if (snooze) begin
              state <= SNOOZED;
              snooze_cnt <= SNOOZE_L;
            end
`endif
            else if (min_tick) begin
              ring_cnt <= ring_cnt - 4'd1;
              if (ring_cnt == 4'd1) state <= IDLE;
            end
`ifdef MULTI_ALARM_SNOOZE_EN
          SNOOZED:
            if (dismiss) state <= IDLE;
            else if (min_tick) begin
              snooze_cnt <= snooze_cnt - 4'd1;
              if (snooze_cnt == 4'd1) begin
                state <= RINGING;
                ring_cnt <= RING_L;
              end
            end
`endif
          default: state <= IDLE;
        endcase
    end
endmodule

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD 24h clock with NUM_ALARMS alarm channels.
// Optional snooze support via MULTI_ALARM_SNOOZE_EN.
module multi_alarm_clock import multi_alarm_clock_pkg::*; #(
  parameter int NUM_ALARMS    = 4,
  parameter int TICKS_PER_MIN = 60,
  parameter int SNOOZE_MIN    = 5,
  parameter int RING_MIN      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_time,
  input  logic [HOUR_W-1:0]     set_hours,
  input  logic [MIN_W-1:0]      set_minutes,
  input  logic                  set_alarm,
  input  logic [2:0]            alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_on,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [HOUR_W-1:0]     hours,
  output logic [MIN_W-1:0]      minutes,
  output logic [NUM_ALARMS-1:0] alarm_active,
  output logic                  alarm_triggered
);
  localparam int PW = $clog2(TICKS_PER_MIN);
  logic [PW-1:0] presc;
  logic min_tick, set_ok, time_load, ev_q;
  assign min_tick = presc == PW'(TICKS_PER_MIN - 1);
  assign set_ok = bcd_valid(set_hours, set_minutes);
  assign time_load = set_time && set_ok;
  assign alarm_triggered = |alarm_active;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      presc <= '0;
      hours <= '0;
      minutes <= '0;
      ev_q <= 1'b0;
    end else begin
      ev_q <= time_load || min_tick;
      if (time_load) begin
        hours <= set_hours;
        minutes <= set_minutes;
        presc <= '0;
      end else begin
        presc <= min_tick ? '0 : presc + 1'b1;
        if (min_tick) begin
          minutes <= bcd_inc_min(minutes);
          if (minutes == MAX_MIN) hours <= bcd_inc_hour(hours);
        end
      end
    end
`ifndef MULTI_ALARM_SNOOZE_EN
  logic unused_snooze;
  localparam int unused_snooze_min = SNOOZE_MIN;
  assign unused_snooze = snooze;
`endif
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
`ifdef MULTI_ALARM_SNOOZE_EN
      .SNOOZE_MIN(SNOOZE_MIN),
`endif
      .RING_MIN(RING_MIN)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .ev(ev_q),
      .min_tick(min_tick),
      .en(alarm_on[i]),
      .load(set_alarm && set_ok && alarm_sel == 3'(i)),
      .dismiss(dismiss),
`ifdef MULTI_ALARM_SNOOZE_EN
      .snooze(snooze),
`endif
      .set_hours(set_hours),
      .set_minutes(set_minutes),
      .hours(hours),
      .minutes(minutes),
      .active(alarm_active[i])
    );
  end
endmodule
